id_ex_register: RTL and testbench
=================================

Name: id_ex_register

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Captures decoded control bits, ALUOp[2:0], the function code and the operand fields produced in ID. Presents them to EX, where ALUOp and function code drive the ALU control decoder.
- Supports stall (hold), flush (bubble insertion) and a global step-enable from the debug unit.

Parameters:
- NB_DATA, 32, width of register-file operands, sign-extended immediate and PC+4
- NB_REG, 5, register address width
- NB_ALUOP, 3, ALUOp width
- NB_FUNC, 6, function code width

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_enable  in  1  debug step-enable; 0 freezes the register
- i_stall  in  1  hazard-unit hold (load-use)
- i_flush  in  1  insert bubble (branch/jump taken, hazard bubble)
- i_valid  in  1  ID holds a real instruction
- i_ctrl  in  9  {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst[1:0], Branch, Jump}
- i_ALUOp  in  NB_ALUOP  from main control
- i_Function_code  in  NB_FUNC  instr[5:0]
- i_shamt  in  5  instr[10:6]
- i_rs_data, i_rt_data  in  NB_DATA  register-file reads
- i_imm  in  NB_DATA  sign-extended immediate
- i_pc4  in  NB_DATA  PC+4
- i_rs, i_rt, i_rd  in  NB_REG  register addresses
- o_valid  out  1
- o_ctrl  out  9
- o_ALUOp  out  NB_ALUOP
- o_Function_code  out  NB_FUNC
- o_shamt  out  5
- o_rs_data, o_rt_data, o_imm, o_pc4  out  NB_DATA
- o_rs, o_rt, o_rd  out  NB_REG

Behaviour:
- All state updates occur on the rising edge of i_clk. Outputs are registered directly, with no combinational path from input to output. Latency is 1 cycle.
- Reset (i_reset=1, synchronous):
  - all outputs go to 0: o_valid=0, o_ctrl=0, o_ALUOp=3'b000, all data and address fields 0.
  - Reset overrides every other input.
- Per-edge priority: reset > !i_enable > flush > stall > load.
  - i_enable=0: hold all fields. A flush or stall presented while i_enable=0 is ignored; it is not remembered.
  - i_flush=1 (enabled): bubble.
    - o_valid=0, o_ctrl=0, o_ALUOp=3'b000, o_Function_code=0.
    - Data and address fields are don't-care; the implementation clears them to 0.
    - A bubble must never assert RegWrite, MemRead, MemWrite, Branch or Jump.
  - i_stall=1 (enabled, no flush): hold every output unchanged. Consecutive stalls hold indefinitely.
  - Otherwise load: every output takes its input, and o_valid=i_valid.
    - If i_valid=0, o_ctrl and o_ALUOp are forced to 0, identical to a bubble.
- Flush and stall asserted in the same cycle: flush wins and produces a bubble.
- Fields are stored at the declared widths, with no sign extension inside the block.
- No handshake beyond stall/enable. The block cannot overflow; it is a single-entry register.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - Adds output o_bubble_count [15:0].
  - Increments on every enabled edge that loads a bubble (flush, or load with i_valid=0). It saturates at 16'hFFFF.
  - Cleared by reset; held when i_enable=0 or while stalled.
- Undefined: the port and counter are absent. Core behaviour is identical in both cases.

Test Plan:
- Reset then load ADDU (i_ctrl=9'b1_0000_0100, i_ALUOp=3'b011, i_Function_code=6'b100001, i_rs_data=32'h5, i_rt_data=32'h7, i_valid=1) -> after 1 edge all outputs match the inputs and o_valid=1; during reset all outputs read 0.
- Load SUBU, then i_stall=1 for 3 edges while inputs change to ANDI (ALUOp=3'b100) -> outputs stay SUBU (ALUOp=3'b011, func=6'b100011) for 3 cycles; the first edge after the stall clears loads ANDI.
- Load SW (MemWrite=1), then i_flush=1 -> next edge o_ctrl=0, o_ALUOp=3'b000, o_valid=0.
- i_flush=1 and i_stall=1 on the same edge with valid LW inputs -> a bubble is produced, not a hold.
- i_enable=0 with i_flush=1 for 2 edges after loading BEQ (ALUOp=3'b001) -> BEQ is held. Setting i_enable=1 with the flush deasserted then loads the new inputs normally.
- ID_EX_BUBBLE_CNT_EN defined: 5 flushes, 2 stalls, 1 load with i_valid=0 -> o_bubble_count=6. Synchronous reset mid-sequence returns the count to 0 on the next edge.

Source files
------------

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with stall, flush and debug step-enable (optional bubble counter: ID_EX_BUBBLE_CNT_EN)
module id_ex_register #(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int NB_ALUOP = 3,
  parameter int NB_FUNC  = 6
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_valid,
  input  logic [8:0]          i_ctrl,
  input  logic [NB_ALUOP-1:0] i_ALUOp,
  input  logic [NB_FUNC-1:0]  i_Function_code,
  input  logic [4:0]          i_shamt,
  input  logic [NB_DATA-1:0]  i_rs_data,
  input  logic [NB_DATA-1:0]  i_rt_data,
  input  logic [NB_DATA-1:0]  i_imm,
  input  logic [NB_DATA-1:0]  i_pc4,
  input  logic [NB_REG-1:0]   i_rs,
  input  logic [NB_REG-1:0]   i_rt,
  input  logic [NB_REG-1:0]   i_rd,
  output logic                o_valid,
  output logic [8:0]          o_ctrl,
  output logic [NB_ALUOP-1:0] o_ALUOp,
  output logic [NB_FUNC-1:0]  o_Function_code,
  output logic [4:0]          o_shamt,
  output logic [NB_DATA-1:0]  o_rs_data,
  output logic [NB_DATA-1:0]  o_rt_data,
  output logic [NB_DATA-1:0]  o_imm,
  output logic [NB_DATA-1:0]  o_pc4,
  output logic [NB_REG-1:0]   o_rs,
  output logic [NB_REG-1:0]   o_rt,
  output logic [NB_REG-1:0]   o_rd
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]         o_bubble_count
`endif
);

  // Per-edge action once reset is excluded: hold (disabled or stalled), bubble, or load.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_LOAD   = 2'd2
  } action_e;

  action_e action;

  logic                valid_q,  valid_d;
  logic [8:0]          ctrl_q,   ctrl_d;
  logic [NB_ALUOP-1:0] aluop_q,  aluop_d;
  logic [NB_FUNC-1:0]  func_q,   func_d;
  logic [4:0]          shamt_q,  shamt_d;
  logic [NB_DATA-1:0]  rs_data_q, rs_data_d;
  logic [NB_DATA-1:0]  rt_data_q, rt_data_d;
  logic [NB_DATA-1:0]  imm_q,    imm_d;
  logic [NB_DATA-1:0]  pc4_q,    pc4_d;
  logic [NB_REG-1:0]   rs_q,     rs_d;
  logic [NB_REG-1:0]   rt_q,     rt_d;
  logic [NB_REG-1:0]   rd_q,     rd_d;

  // Priority decode: a disabled debug step swallows flush/stall entirely; flush beats stall.
  always_comb begin
    action = ACT_HOLD;
    if (!i_enable) begin
      action = ACT_HOLD;
    end else if (i_flush) begin
      action = ACT_BUBBLE;
    end else if (i_stall) begin
      action = ACT_HOLD;
    end else begin
      action = ACT_LOAD;
    end
  end

  // Next-state for every field; an invalid ID slot loads its data but never its control.
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    aluop_d   = aluop_q;
    func_d    = func_q;
    shamt_d   = shamt_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    pc4_d     = pc4_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    case (action)
      ACT_BUBBLE: begin
        valid_d   = 1'b0;
        ctrl_d    = '0;
        aluop_d   = '0;
        func_d    = '0;
        shamt_d   = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        pc4_d     = '0;
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
      end
      ACT_LOAD: begin
        valid_d   = i_valid;
        ctrl_d    = i_valid ? i_ctrl  : '0;
        aluop_d   = i_valid ? i_ALUOp : '0;
        func_d    = i_Function_code;
        shamt_d   = i_shamt;
        rs_data_d = i_rs_data;
        rt_data_d = i_rt_data;
        imm_d     = i_imm;
        pc4_d     = i_pc4;
        rs_d      = i_rs;
        rt_d      = i_rt;
        rd_d      = i_rd;
      end
      default: begin
        valid_d   = valid_q;
      end
    endcase
  end

  // Pipeline register; synchronous reset clears every field.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      aluop_q   <= '0;
      func_q    <= '0;
      shamt_q   <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      pc4_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      aluop_q   <= aluop_d;
      func_q    <= func_d;
      shamt_q   <= shamt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      pc4_q     <= pc4_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  assign o_valid         = valid_q;
  assign o_ctrl          = ctrl_q;
  assign o_ALUOp         = aluop_q;
  assign o_Function_code = func_q;
  assign o_shamt         = shamt_q;
  assign o_rs_data       = rs_data_q;
  assign o_rt_data       = rt_data_q;
  assign o_imm           = imm_q;
  assign o_pc4           = pc4_q;
  assign o_rs            = rs_q;
  assign o_rt            = rt_q;
  assign o_rd            = rd_q;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        bubble_loaded;

  // A bubble enters EX on a flush or on a load of an empty ID slot.
  always_comb begin
    bubble_loaded = (action == ACT_BUBBLE) || ((action == ACT_LOAD) && !i_valid);
    bubble_cnt_d  = bubble_cnt_q;
    if (bubble_loaded && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // Saturating bubble counter, cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// tb/tb_id_ex_register.sv - directed-vector bench for id_ex_register
module tb_id_ex_register;

  logic        clk = 1'b0;
  logic        reset, enable, stall, flush, valid;
  logic [8:0]  ctrl;
  logic [2:0]  aluop;
  logic [5:0]  func;
  logic [4:0]  shamt;
  logic [31:0] rs_data, rt_data, imm, pc4;
  logic [4:0]  rs, rt, rd;

  logic        o_valid;
  logic [8:0]  o_ctrl;
  logic [2:0]  o_aluop;
  logic [5:0]  o_func;
  logic [4:0]  o_shamt;
  logic [31:0] o_rs_data, o_rt_data, o_imm, o_pc4;
  logic [4:0]  o_rs, o_rt, o_rd;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] o_bubble_count;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [8:0] C_RTYPE = 9'b1_0000_0100;
  localparam logic [8:0] C_ANDI  = 9'b1_0001_0000;
  localparam logic [8:0] C_SW    = 9'b0_0101_0000;
  localparam logic [8:0] C_LW    = 9'b1_1011_0000;
  localparam logic [8:0] C_BEQ   = 9'b0_0000_0010;

  id_ex_register dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_stall(stall),
    .i_flush(flush), .i_valid(valid), .i_ctrl(ctrl), .i_ALUOp(aluop),
    .i_Function_code(func), .i_shamt(shamt), .i_rs_data(rs_data),
    .i_rt_data(rt_data), .i_imm(imm), .i_pc4(pc4), .i_rs(rs), .i_rt(rt),
    .i_rd(rd), .o_valid(o_valid), .o_ctrl(o_ctrl), .o_ALUOp(o_aluop),
    .o_Function_code(o_func), .o_shamt(o_shamt), .o_rs_data(o_rs_data),
    .o_rt_data(o_rt_data), .o_imm(o_imm), .o_pc4(o_pc4), .o_rs(o_rs),
    .o_rt(o_rt), .o_rd(o_rd)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .o_bubble_count(o_bubble_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] c, input logic [2:0] op,
                       input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] p,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    valid = v; ctrl = c; aluop = op; func = f; shamt = sh;
    rs_data = a; rt_data = b; imm = im; pc4 = p; rs = s; rt = t; rd = d;
  endtask

  task automatic expect_all(input string tag, input logic v, input logic [8:0] c,
                            input logic [2:0] op, input logic [5:0] f, input logic [4:0] sh,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] im, input logic [31:0] p,
                            input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    check_eq({tag, ".valid"}, 64'(o_valid), 64'(v));
    check_eq({tag, ".ctrl"},  64'(o_ctrl),  64'(c));
    check_eq({tag, ".aluop"}, 64'(o_aluop), 64'(op));
    check_eq({tag, ".func"},  64'(o_func),  64'(f));
    check_eq({tag, ".shamt"}, 64'(o_shamt), 64'(sh));
    check_eq({tag, ".rs_data"}, 64'(o_rs_data), 64'(a));
    check_eq({tag, ".rt_data"}, 64'(o_rt_data), 64'(b));
    check_eq({tag, ".imm"},   64'(o_imm),   64'(im));
    check_eq({tag, ".pc4"},   64'(o_pc4),   64'(p));
    check_eq({tag, ".rs"},    64'(o_rs),    64'(s));
    check_eq({tag, ".rt"},    64'(o_rt),    64'(t));
    check_eq({tag, ".rd"},    64'(o_rd),    64'(d));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; stall = 1'b0; flush = 1'b0;
    // ADDU presented during reset: outputs must stay 0
    drive(1'b1, C_RTYPE, 3'b011, 6'b100001, 5'd0, 32'h5, 32'h7, 32'h0, 32'h4, 5'd1, 5'd2, 5'd3);
    step();
    step();
    expect_all("reset", 1'b0, 9'h0, 3'h0, 6'h0, 5'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0, 5'h0, 5'h0);

    reset = 1'b0;
    step();
    expect_all("addu", 1'b1, C_RTYPE, 3'b011, 6'b100001, 5'd0, 32'h5, 32'h7, 32'h0, 32'h4, 5'd1, 5'd2, 5'd3);

    // SUBU then three stalled edges with ANDI on the inputs
    drive(1'b1, C_RTYPE, 3'b011, 6'b100011, 5'd0, 32'h9, 32'h4, 32'h0, 32'h8, 5'd4, 5'd5, 5'd6);
    step();
    expect_all("subu", 1'b1, C_RTYPE, 3'b011, 6'b100011, 5'd0, 32'h9, 32'h4, 32'h0, 32'h8, 5'd4, 5'd5, 5'd6);
    drive(1'b1, C_ANDI, 3'b100, 6'b001100, 5'd0, 32'h1234, 32'h0, 32'h0000FFFF, 32'hC, 5'd7, 5'd8, 5'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("stall%0d.aluop", i), 64'(o_aluop), 64'(3'b011));
      check_eq($sformatf("stall%0d.func", i),  64'(o_func),  64'(6'b100011));
      check_eq($sformatf("stall%0d.rs_data", i), 64'(o_rs_data), 64'h9);
    end
    stall = 1'b0;
    step();
    expect_all("andi", 1'b1, C_ANDI, 3'b100, 6'b001100, 5'd0, 32'h1234, 32'h0, 32'h0000FFFF, 32'hC, 5'd7, 5'd8, 5'd0);

    // SW then flush
    drive(1'b1, C_SW, 3'b000, 6'b000000, 5'd0, 32'h100, 32'hABCD, 32'h10, 32'h10, 5'd9, 5'd10, 5'd0);
    step();
    check_eq("sw.ctrl", 64'(o_ctrl), 64'(C_SW));
    flush = 1'b1;
    step();
    expect_all("flush", 1'b0, 9'h0, 3'h0, 6'h0, 5'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0, 5'h0, 5'h0);
    flush = 1'b0;

    // LW loaded, then flush and stall together with different inputs -> bubble
    drive(1'b1, C_LW, 3'b000, 6'b000000, 5'd0, 32'h200, 32'h0, 32'h20, 32'h14, 5'd11, 5'd12, 5'd0);
    step();
    check_eq("lw.ctrl", 64'(o_ctrl), 64'(C_LW));
    check_eq("lw.valid", 64'(o_valid), 64'h1);
    drive(1'b1, C_LW, 3'b000, 6'b000000, 5'd0, 32'h300, 32'h0, 32'h24, 32'h18, 5'd13, 5'd14, 5'd0);
    flush = 1'b1; stall = 1'b1;
    step();
    check_eq("fl_st.valid", 64'(o_valid), 64'h0);
    check_eq("fl_st.ctrl",  64'(o_ctrl),  64'h0);
    check_eq("fl_st.rs_data", 64'(o_rs_data), 64'h0);
    flush = 1'b0; stall = 1'b0;

    // BEQ held while disabled despite flush
    drive(1'b1, C_BEQ, 3'b001, 6'b000000, 5'd0, 32'hA, 32'hB, 32'h3, 32'h1C, 5'd15, 5'd16, 5'd0);
    step();
    check_eq("beq.aluop", 64'(o_aluop), 64'(3'b001));
    drive(1'b1, C_RTYPE, 3'b011, 6'b100001, 5'd0, 32'h55, 32'h66, 32'h0, 32'h20, 5'd17, 5'd18, 5'd19);
    enable = 1'b0; flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      expect_all($sformatf("dis%0d", i), 1'b1, C_BEQ, 3'b001, 6'b000000, 5'd0, 32'hA, 32'hB, 32'h3, 32'h1C, 5'd15, 5'd16, 5'd0);
    end
    enable = 1'b1; flush = 1'b0;
    step();
    expect_all("reen", 1'b1, C_RTYPE, 3'b011, 6'b100001, 5'd0, 32'h55, 32'h66, 32'h0, 32'h20, 5'd17, 5'd18, 5'd19);

    // Load of an invalid slot: control forced to 0, data still captured, full widths kept
    drive(1'b0, 9'h1FF, 3'b111, 6'b111111, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 32'hDEAD_BEEF, 32'hCAFE_0004, 5'd31, 5'd30, 5'd29);
    step();
    expect_all("inv", 1'b0, 9'h0, 3'h0, 6'b111111, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 32'hDEAD_BEEF, 32'hCAFE_0004, 5'd31, 5'd30, 5'd29);

    // Reset overrides a disabled step
    enable = 1'b0; reset = 1'b1;
    step();
    expect_all("rst_dis", 1'b0, 9'h0, 3'h0, 6'h0, 5'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0, 5'h0, 5'h0);
    enable = 1'b1; reset = 1'b0;

`ifdef ID_EX_BUBBLE_CNT_EN
    check_eq("cnt.reset", 64'(o_bubble_count), 64'h0);
    drive(1'b1, C_RTYPE, 3'b011, 6'b100001, 5'd0, 32'h5, 32'h7, 32'h0, 32'h4, 5'd1, 5'd2, 5'd3);
    flush = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check_eq("cnt.flush5", 64'(o_bubble_count), 64'd5);
    flush = 1'b0; stall = 1'b1;
    for (int i = 0; i < 2; i++) step();
    check_eq("cnt.stall", 64'(o_bubble_count), 64'd5);
    stall = 1'b0; valid = 1'b0;
    step();
    check_eq("cnt.inv", 64'(o_bubble_count), 64'd6);
    enable = 1'b0; flush = 1'b1;
    step();
    check_eq("cnt.dis", 64'(o_bubble_count), 64'd6);
    enable = 1'b1; flush = 1'b0; valid = 1'b1;
    step();
    check_eq("cnt.load", 64'(o_bubble_count), 64'd6);
    reset = 1'b1;
    step();
    check_eq("cnt.rst", 64'(o_bubble_count), 64'd0);
    reset = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
